// File: rtl/dct_mac_sequencer.sv
// dct_mac_sequencer
// Sequences N (sample, coefficient) multiplies through a shared start/done
// multiplier, accumulates the signed products, then rounds, shifts and
// saturates the sum into one DW-bit DCT coefficient held until consumed.
module dct_mac_sequencer #(
   parameter int N     = 8,
   parameter int DW    = 16,
   parameter int PW    = 32,
   parameter int ACCW  = 35,
   parameter int SHIFT = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] x_in,
   input  logic [DW-1:0] c_in,
   output logic [DW-1:0] mul_a,
   output logic [DW-1:0] mul_b,
   output logic          mul_start,
   input  logic          mul_done,
   input  logic [PW-1:0] mul_p,
   output logic          y_valid,
   input  logic          y_ready,
   output logic [DW-1:0] y_out,
   output logic          y_sat
);

   // Term counter width; N is a power of two so the counter wraps cleanly.
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   // One guard bit above the accumulator so adding the rounding constant
   // can never wrap.
   localparam int RW = ACCW + 1;
   // Half an LSB of the output, i.e. 2^(SHIFT-1), for round-half-up.
   localparam logic [RW-1:0] HALF = {{(RW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
   localparam logic [DW-1:0] Y_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] Y_MIN = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_ACC,
      S_OUT
   } state_t;

   state_t          state_reg;
   state_t          state_next;
   logic [ACCW-1:0] acc_reg;
   logic [CW-1:0]   count_reg;
   logic [PW-1:0]   prod_reg;
   logic            wait_first_reg;
   logic [DW-1:0]   mul_a_reg;
   logic [DW-1:0]   mul_b_reg;
   logic            y_valid_reg;
   logic [DW-1:0]   y_out_reg;
   logic            y_sat_reg;

   logic [ACCW-1:0]       prod_ext;
   logic [ACCW-1:0]       acc_sum;
   logic [RW-1:0]         rnd_sum;
   logic signed [RW-1:0]  rnd_shr;
   logic                  pos_ovf;
   logic                  neg_ovf;
   logic [DW-1:0]         sat_y;
   logic                  sat_flag;
   logic                  last_term;
   logic                  done_seen;

   // Sign-extend the latched product up to the accumulator width, bit by bit.
   genvar gi;
   generate
      for (gi = 0; gi < ACCW; gi++) begin : g_sext
         if (gi < PW) begin : g_lo
            assign prod_ext[gi] = prod_reg[gi];
         end else begin : g_hi
            assign prod_ext[gi] = prod_reg[PW-1];
         end
      end
   endgenerate

   // Running sum including the product being accumulated this cycle; the
   // output stage works on this value so the result is ready on OUT entry.
   assign acc_sum = acc_reg + prod_ext;

   // Round half up, then arithmetic shift; bits above DW-1 must all equal
   // the sign bit or the value does not fit the output width.
   assign rnd_sum  = {acc_sum[ACCW-1], acc_sum} + HALF;
   assign rnd_shr  = $signed(rnd_sum) >>> SHIFT;
   assign pos_ovf  = !rnd_shr[RW-1] && (|rnd_shr[RW-1:DW-1]);
   assign neg_ovf  = rnd_shr[RW-1] && !(&rnd_shr[RW-1:DW-1]);
   assign sat_flag = pos_ovf || neg_ovf;
   assign sat_y    = pos_ovf ? Y_MAX : (neg_ovf ? Y_MIN : rnd_shr[DW-1:0]);

   assign last_term = (count_reg == CW'(N - 1));
   // The multiplier may still show the previous done in the first WAIT
   // cycle, so done is only trusted from the second WAIT cycle on.
   assign done_seen = !wait_first_reg && mul_done;

   assign mul_a   = mul_a_reg;
   assign mul_b   = mul_b_reg;
   assign y_valid = y_valid_reg;
   assign y_out   = y_out_reg;
   assign y_sat   = y_sat_reg;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode plus the handshake/strobe outputs that follow state.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      mul_start  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            state_next = S_LOAD;
         end
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = S_START;
            end
         end
         S_START: begin
            mul_start  = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (done_seen) begin
               state_next = S_ACC;
            end
         end
         S_ACC: begin
            state_next = last_term ? S_OUT : S_LOAD;
         end
         S_OUT: begin
            if (y_ready) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: operand capture, product latch, accumulation and result hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg        <= '0;
         count_reg      <= '0;
         prod_reg       <= '0;
         wait_first_reg <= 1'b0;
         mul_a_reg      <= '0;
         mul_b_reg      <= '0;
         y_valid_reg    <= 1'b0;
         y_out_reg      <= '0;
         y_sat_reg      <= 1'b0;
      end else begin
         wait_first_reg <= (state_reg == S_START);
         if (state_reg == S_IDLE) begin
            acc_reg   <= '0;
            count_reg <= '0;
         end
         if ((state_reg == S_LOAD) && in_valid) begin
            mul_a_reg <= x_in;
            mul_b_reg <= c_in;
         end
         if ((state_reg == S_WAIT) && done_seen) begin
            prod_reg <= mul_p;
         end
         if (state_reg == S_ACC) begin
            acc_reg   <= acc_sum;
            count_reg <= count_reg + CW'(1);
            if (last_term) begin
               y_out_reg   <= sat_y;
               y_sat_reg   <= sat_flag;
               y_valid_reg <= 1'b1;
            end
         end
         if ((state_reg == S_OUT) && y_ready) begin
            y_valid_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// tb_dct_mac_sequencer
// Drives blocks of 8 pairs into the sequencer, emulates a start/done
// multiplier with random latency and optional stale done, and compares each
// coefficient with a plain-arithmetic golden (sum, round, shift, saturate).
module tb_dct_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] x_in = '0;
   logic [15:0] c_in = '0;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic        mul_start;
   logic        mul_done;
   logic [31:0] mul_p;
   logic        y_valid;
   logic        y_ready = 1'b0;
   logic [15:0] y_out;
   logic        y_sat;

   int n_cmp = 0;
   int n_err = 0;
   int start_cnt = 0;
   logic stale_mode = 1'b0;
   logic mbusy;
   int   mcnt;

   logic signed [15:0] xs [8];
   logic signed [15:0] cs [8];

   always #5 clk = ~clk;

   dct_mac_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .c_in      (c_in),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_start (mul_start),
      .mul_done  (mul_done),
      .mul_p     (mul_p),
      .y_valid   (y_valid),
      .y_ready   (y_ready),
      .y_out     (y_out),
      .y_sat     (y_sat)
   );

   // Multiplier model: 1..20 cycles after the first WAIT cycle it raises done
   // with the true product; in stale mode done stays high after completion and
   // through the cycle after the next start, with garbage on mul_p.
   always @(posedge clk) begin
      if (!rst_n) begin
         mbusy    <= 1'b0;
         mcnt     <= 0;
         mul_done <= 1'b0;
         mul_p    <= '0;
      end else if (mul_start) begin
         start_cnt <= start_cnt + 1;
         mbusy     <= 1'b1;
         mcnt      <= int'($urandom_range(20, 1));
         if (stale_mode) begin
            mul_done <= 1'b1;
            mul_p    <= $urandom;
         end else begin
            mul_done <= 1'b0;
         end
      end else if (mbusy) begin
         if (mcnt == 1) begin
            mul_done <= 1'b1;
            mul_p    <= $signed(mul_a) * $signed(mul_b);
            mbusy    <= 1'b0;
         end else begin
            mcnt     <= mcnt - 1;
            mul_done <= 1'b0;
         end
      end else if (!stale_mode) begin
         mul_done <= 1'b0;
      end
   end

   // Golden coefficient from the current xs/cs table.
   function automatic void golden(output logic [15:0] y, output logic s);
      longint sum = 0;
      longint r;
      for (int i = 0; i < 8; i++) begin
         sum += longint'(xs[i]) * longint'(cs[i]);
      end
      r = (sum + 64'sd16384) >>> 15;
      if (r > 32767) begin
         y = 16'h7fff;
         s = 1'b1;
      end else if (r < -32768) begin
         y = 16'h8000;
         s = 1'b1;
      end else begin
         y = 16'(r);
         s = 1'b0;
      end
   endfunction

   // Called on a negedge; holds the pair until the handshake edge has passed.
   task automatic send_pair(input logic [15:0] x, input logic [15:0] c);
      int t = 0;
      in_valid = 1'b1;
      x_in     = x;
      c_in     = c;
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_pair_timeout: in_ready=%0b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_all();
      for (int i = 0; i < 8; i++) begin
         send_pair(xs[i], cs[i]);
      end
   endtask

   task automatic wait_y();
      int t = 0;
      while (!y_valid && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_y_timeout: y_valid=%0b required 1", y_valid);
      end
   endtask

   // Full block: send 8 pairs, wait for the result, release it after a delay.
   task automatic run_block(input int ready_delay, output logic [15:0] y, output logic s);
      send_all();
      wait_y();
      y = y_out;
      s = y_sat;
      $display("block: y_out=%0d y_sat=%0b", $signed(y), s);
      repeat (ready_delay) @(negedge clk);
      y_ready = 1'b1;
      @(negedge clk);
      y_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({in_ready, mul_start, y_valid, y_sat, y_out, mul_a, mul_b} !== 51'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %0h required 0",
                  {in_ready, mul_start, y_valid, y_sat, y_out, mul_a, mul_b});
      end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle_ready: in_ready=%0b required 0", in_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_load_ready: in_ready=%0b required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      logic [15:0] y;
      logic s;
      int st0;
      for (int i = 0; i < 8; i++) begin
         xs[i] = 16'sd1000;
         cs[i] = 16'sd16384;
      end
      st0 = start_cnt;
      run_block(0, y, s);
      n_cmp++;
      if (y !== 16'd4000 || s !== 1'b0) begin
         n_err++;
         $display("FAIL basic_result: y=%0d sat=%0b required 4000 sat=0", $signed(y), s);
      end
      n_cmp++;
      if (start_cnt - st0 != 8) begin
         n_err++;
         $display("FAIL basic_starts: starts=%0d required 8", start_cnt - st0);
      end
   endtask

   task automatic test_saturation();
      logic [15:0] y;
      logic s;
      for (int i = 0; i < 8; i++) begin
         xs[i] = 16'sd32767;
         cs[i] = 16'sd32767;
      end
      run_block(1, y, s);
      n_cmp++;
      if (y !== 16'h7fff || s !== 1'b1) begin
         n_err++;
         $display("FAIL sat_pos: y=%0d sat=%0b required 32767 sat=1", $signed(y), s);
      end
      for (int i = 0; i < 8; i++) begin
         xs[i] = -16'sd32768;
         cs[i] = 16'sd32767;
      end
      run_block(0, y, s);
      n_cmp++;
      if (y !== 16'h8000 || s !== 1'b1) begin
         n_err++;
         $display("FAIL sat_neg: y=%0d sat=%0b required -32768 sat=1", $signed(y), s);
      end
   endtask

   task automatic test_rounding();
      logic [15:0] y;
      logic s;
      for (int i = 0; i < 8; i++) begin
         xs[i] = (i == 0) ? 16'sd1 : 16'sd0;
         cs[i] = 16'sd16384;
      end
      run_block(0, y, s);
      n_cmp++;
      if (y !== 16'd1 || s !== 1'b0) begin
         n_err++;
         $display("FAIL round_half_up: y=%0d sat=%0b required 1 sat=0", $signed(y), s);
      end
      for (int i = 0; i < 8; i++) begin
         xs[i] = -16'sd1;
         cs[i] = 16'sd1;
      end
      run_block(2, y, s);
      n_cmp++;
      if (y !== 16'd0 || s !== 1'b0) begin
         n_err++;
         $display("FAIL round_small_neg: y=%0d sat=%0b required 0 sat=0", $signed(y), s);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] ey;
      logic es;
      int st0;
      for (int i = 0; i < 8; i++) begin
         xs[i] = 16'($urandom);
         cs[i] = 16'($urandom);
      end
      golden(ey, es);
      send_all();
      wait_y();
      st0 = start_cnt;
      $display("backpressure block: y_out=%0d y_sat=%0b", $signed(y_out), y_sat);
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (y_valid !== 1'b1 || y_out !== ey || y_sat !== es) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: v=%0b y=%0d sat=%0b required v=1 y=%0d sat=%0b",
                     k, y_valid, $signed(y_out), y_sat, $signed(ey), es);
         end
         n_cmp++;
         if (in_ready !== 1'b0 || start_cnt != st0) begin
            n_err++;
            $display("FAIL bp_quiet[%0d]: in_ready=%0b new_starts=%0d required 0/0",
                     k, in_ready, start_cnt - st0);
         end
         @(negedge clk);
      end
      y_ready = 1'b1;
      @(negedge clk);
      y_ready = 1'b0;
      n_cmp++;
      if (y_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release: y_valid=%0b in_ready=%0b required 0/0", y_valid, in_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_reload: in_ready=%0b required 1", in_ready);
      end
   endtask

   task automatic test_random();
      logic [15:0] y, ey;
      logic s, es;
      int st0;
      for (int b = 0; b < 8; b++) begin
         stale_mode = b[0];
         for (int i = 0; i < 8; i++) begin
            xs[i] = 16'($urandom);
            cs[i] = 16'($urandom);
         end
         if (b == 7) begin
            for (int i = 0; i < 8; i++) begin
               xs[i] = -16'sd32768;
               cs[i] = -16'sd32768;
            end
         end
         golden(ey, es);
         st0 = start_cnt;
         run_block(int'($urandom_range(3, 0)), y, s);
         n_cmp++;
         if (y !== ey || s !== es) begin
            n_err++;
            $display("FAIL random_block[%0d]: y=%0d sat=%0b required y=%0d sat=%0b",
                     b, $signed(y), s, $signed(ey), es);
         end
         n_cmp++;
         if (start_cnt - st0 != 8) begin
            n_err++;
            $display("FAIL random_starts[%0d]: starts=%0d required 8", b, start_cnt - st0);
         end
      end
      stale_mode = 1'b0;
   endtask

   task automatic test_reset_abort();
      logic [15:0] y, ey;
      logic s, es;
      for (int i = 0; i < 8; i++) begin
         xs[i] = 16'sd20000;
         cs[i] = 16'sd30000;
      end
      for (int i = 0; i < 4; i++) begin
         send_pair(xs[i], cs[i]);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, mul_start, y_valid, y_sat, y_out, mul_a, mul_b} !== 51'd0) begin
         n_err++;
         $display("FAIL abort_outputs: got %0h required 0",
                  {in_ready, mul_start, y_valid, y_sat, y_out, mul_a, mul_b});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         xs[i] = 16'($urandom_range(2000, 0));
         cs[i] = 16'($urandom);
      end
      golden(ey, es);
      run_block(0, y, s);
      n_cmp++;
      if (y !== ey || s !== es) begin
         n_err++;
         $display("FAIL abort_new_block: y=%0d sat=%0b required y=%0d sat=%0b",
                  $signed(y), s, $signed(ey), es);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_rounding();
      test_backpressure();
      test_random();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
